// File: rtl/led_channel_ctrl.sv
// Multi-channel LED driver: shared tick prescaler and PWM counter, with a per-channel
// OFF / ON / BLINK / PWM mode loaded through a single-cycle write port.
module led_channel_ctrl #(
    parameter int CLK_HZ       = 25000000,
    parameter int TICK_HZ      = 1000,
    parameter int CHANNELS     = 4,
    parameter int PER_W        = 16,
    parameter int PWM_W        = 8,
    parameter int PER_RESET    = 500,
    parameter int RESET_BLINK0 = 1,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PER_W-1:0]    cfg_period,
    input  logic [PWM_W-1:0]    cfg_duty,
    output logic [CHANNELS-1:0] led_out,
    output logic                tick_out
);

    localparam int DIV   = CLK_HZ / TICK_HZ - 1;
    localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1;

    localparam logic [CNT_W-1:0] DIV_V     = CNT_W'(DIV);
    localparam logic [PER_W-1:0] PER_RST_V = PER_W'(PER_RESET);
    localparam logic [CH_W:0]    CH_LIMIT  = (CH_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    logic [CNT_W-1:0]    presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [PWM_W-1:0]    pwm_q, pwm_d;
    logic [CHANNELS-1:0] led_q, led_d;
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic                cfgHit;

    mode_e            mode_q     [CHANNELS];
    mode_e            mode_d     [CHANNELS];
    logic [PER_W-1:0] period_q   [CHANNELS];
    logic [PER_W-1:0] period_d   [CHANNELS];
    logic [PWM_W-1:0] duty_q     [CHANNELS];
    logic [PWM_W-1:0] duty_d     [CHANNELS];
    logic [PER_W-1:0] blinkCnt_q [CHANNELS];
    logic [PER_W-1:0] blinkCnt_d [CHANNELS];

    // tick_q is high during the cycle where the prescaler sits at DIV, so blink
    // counters advance on the edge that ends that cycle.
    always_comb begin
        presc_d = (presc_q == DIV_V) ? '0 : presc_q + CNT_W'(1);
        tick_d  = (presc_d == DIV_V);
        pwm_d   = pwm_q + PWM_W'(1);
        cfgHit  = cfg_we && ({1'b0, cfg_ch} < CH_LIMIT);
        phase_d = phase_q;
        led_d   = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            mode_d[i]     = mode_q[i];
            period_d[i]   = period_q[i];
            duty_d[i]     = duty_q[i];
            blinkCnt_d[i] = blinkCnt_q[i];

            // A write to this channel takes priority over a coincident tick.
            if (cfgHit && (cfg_ch == CH_W'(i))) begin
                mode_d[i]     = mode_e'(cfg_mode);
                period_d[i]   = cfg_period;
                duty_d[i]     = cfg_duty;
                blinkCnt_d[i] = '0;
                phase_d[i]    = 1'b0;
            end else if (tick_q) begin
                if (blinkCnt_q[i] == ((period_q[i] == '0) ? '0 : period_q[i] - PER_W'(1))) begin
                    blinkCnt_d[i] = '0;
                    phase_d[i]    = ~phase_q[i];
                end else begin
                    blinkCnt_d[i] = blinkCnt_q[i] + PER_W'(1);
                end
            end

            case (mode_d[i])
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_BLINK: led_d[i] = phase_d[i];
                MODE_PWM:   led_d[i] = (pwm_d < duty_d[i]);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            pwm_q   <= '0;
            led_q   <= '0;
            phase_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]     <= ((i == 0) && (RESET_BLINK0 != 0)) ? MODE_BLINK : MODE_OFF;
                period_q[i]   <= PER_RST_V;
                duty_q[i]     <= '0;
                blinkCnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            pwm_q   <= pwm_d;
            led_q   <= led_d;
            phase_q <= phase_d;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]     <= mode_d[i];
                period_q[i]   <= period_d[i];
                duty_q[i]     <= duty_d[i];
                blinkCnt_q[i] <= blinkCnt_d[i];
            end
        end
    end

    assign led_out  = led_q;
    assign tick_out = tick_q;

endmodule

// File: doc/led_channel_ctrl.md
# led_channel_ctrl

Multi-channel LED driver and parametrised successor of the single-LED half-second blinker. It derives a shared tick from the board oscillator (25 MHz on the Colorlight i9+). Each of CHANNELS outputs can be set to OFF, ON, BLINK with a programmable half-period, or PWM brightness. It sits between the clock input and the board LED pins and is configured through a single-cycle write port. With default parameters, channel 0 reproduces the legacy 0.5 s toggle out of reset.

## Interface
- CLK_HZ, 25000000, input clock frequency.
- TICK_HZ, 1000, tick rate; one tick = 1 ms by default. CLK_HZ/TICK_HZ must be an integer and at least 2.
- CHANNELS, 4, number of LED outputs (1..16).
- PER_W, 16, width of the blink half-period, in ticks.
- PWM_W, 8, width of the PWM duty value and of the PWM counter.
- PER_RESET, 500, blink half-period loaded into every channel at reset.
- RESET_BLINK0, 1, if 1, channel 0 comes out of reset in BLINK; otherwise OFF.
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous and active-low; one clock, sampled on the rising clk edge.
- cfg_we  input  1  single-cycle write strobe, always accepted (no back-pressure).
- cfg_ch  input  max(1,$clog2(CHANNELS))  target channel of the write.
- cfg_mode  input  2  mode code: 0 OFF, 1 ON, 2 BLINK, 3 PWM.
- cfg_period  input  PER_W  blink half-period in ticks.
- cfg_duty  input  PWM_W  PWM high count per PWM frame.
- led_out  output  CHANNELS  registered LED drive, active-high.
- tick_out  output  1  registered one-clock pulse per tick.

## Operation
- Prescaler:
  - DIV = CLK_HZ/TICK_HZ − 1; counter width is $clog2(DIV+1).
  - The counter counts 0..DIV and wraps to 0.
  - tick_out is high during the cycle in which the counter equals DIV.
- Per-channel registers: mode, period, duty, blink counter (PER_W bits) and blink phase (1 bit).
- Shared PWM counter: PWM_W bits, increments every clk, wraps modulo 2^PWM_W.
- Write:
  - On an edge where cfg_we=1 and cfg_ch<CHANNELS, the addressed channel loads mode, period and duty.
  - The same edge clears that channel's blink counter and blink phase.
  - Writes with cfg_ch≥CHANNELS are ignored.
  - Other channels are never disturbed by a write.
- BLINK:
  - The blink counter advances only on tick cycles.
  - Effective half-period P = period, with period=0 treated as 1.
  - On a tick with counter = P−1: the counter goes to 0 and the phase toggles. On any other tick: the counter increments.
- led_out per mode, recomputed every edge from the post-edge state:
  - OFF: 0.
  - ON: 1.
  - BLINK: equals the phase.
  - PWM: 1 when the next PWM counter value < duty.
- PWM consequences: duty=0 is always off; duty=2^PWM_W−1 is high for 2^PWM_W−1 of every 2^PWM_W clocks.
- Reset values:
  - led_out=0, tick_out=0; prescaler, PWM counter and all blink counters and phases 0.
  - All periods = PER_RESET, all duties 0.
  - All modes OFF, except channel 0 = BLINK when RESET_BLINK0=1.

## Timing
- Write latency: a write sampled at edge k is reflected in led_out from edge k. For example, ON gives led_out high in the cycle after the write cycle.
- BLINK after reset or a write: the first toggle (0→1) happens on the edge ending the P-th tick cycle. After that, the output toggles every P·(DIV+1) clk.
- Ticks are shared and free-running: the first post-write tick arrives after anywhere from 1 to DIV+1 clk.
- A write never resets the prescaler or the PWM counter.
- Write and tick on the same channel in the same cycle: the write wins. The counter and phase clear and that tick is not counted.
- Writing BLINK to a channel already in BLINK restarts its phase at 0.
- Reset asserted mid-operation: every register takes its reset value on that edge and tick_out drops immediately. Operation resumes from the prescaler at 0 on the first edge with rst_n=1.
- Mode changes away from PWM take effect without waiting for the end of the PWM frame.

## Test plan
- Reset with CLK_HZ=100, TICK_HZ=10, PER_RESET=3, RESET_BLINK0=1 -> tick_out pulses in every 10th cycle; led_out[0] rises 30 clk after rst_n release, then toggles every 30 clk; led_out[3:1]=0.
- Write ch2 ON, then ch2 OFF two cycles later -> led_out[2] high for exactly 2 clk, starting the cycle after the first write; other bits unchanged.
- Write ch1 PWM with duty=64, PWM_W=8 -> led_out[1] high for exactly 64 of every 256 clk; duty=0 gives 0 high clk; duty=255 gives 255 high clk.
- Write ch3 BLINK period=0 -> led_out[3] toggles on every tick (10 clk). Write ch3 BLINK period=2 in the same cycle as a tick -> that tick is ignored and the first toggle comes on the 2nd subsequent tick.
- Write with cfg_ch=5 when CHANNELS=5 -> no register or output changes.
- Pulse rst_n low for one cycle while ch0 BLINK is high and ch1 PWM is active -> the next edge gives led_out=0 and tick_out=0; the reset blink sequence restarts exactly as in the first test.
